// File: rtl/reaction_timer.sv
// Reaction timer: arms with the light sequence, times lights-out to key press in ms ticks.
// Optional best-time register and o_best port enabled by defining REACTION_BEST_EN.
module reaction_timer #(
  parameter int unsigned MS_W        = 10,
  parameter int unsigned TIMEOUT_MS  = 999,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            i_clk,
  input  logic            i_srst_n,
  input  logic            i_tick,
  input  logic            i_armed,
  input  logic            i_go,
  input  logic            i_key_n,
  output logic            o_busy,
  output logic            o_valid,
  output logic [MS_W-1:0] o_reactionMs,
  output logic            o_falseStart,
  output logic            o_timeout
`ifdef REACTION_BEST_EN
  ,
  output logic [MS_W-1:0] o_best
`endif
);

  localparam logic [MS_W-1:0] TimeoutVal = MS_W'(TIMEOUT_MS);
  localparam logic [MS_W-1:0] LastVal    = MS_W'(TIMEOUT_MS - 1);
  localparam logic [MS_W-1:0] One        = MS_W'(1);

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StTiming,
    StDone,
    StFalse,
    StTout
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   key_prev_q;
  logic                   armed_q;
  logic [MS_W-1:0]        count_q, count_d;
  logic [MS_W-1:0]        react_q, react_d;
  logic                   valid_q, valid_d;
  logic                   false_q, false_d;
  logic                   tout_q, tout_d;
  logic                   key_s;
  logic                   press;
  logic                   arm_rise;
`ifdef REACTION_BEST_EN
  logic [MS_W-1:0]        best_q, best_d;
`endif

  // Key is active-low: a press is the synchronised key going from 1 to 0.
  assign key_s    = sync_q[SYNC_STAGES-1];
  assign press    = key_prev_q & ~key_s;
  assign arm_rise = i_armed & ~armed_q;

  always_ff @(posedge i_clk) begin
    if (!i_srst_n) begin
      state_q    <= StIdle;
      sync_q     <= '1;
      key_prev_q <= 1'b1;
      armed_q    <= 1'b0;
      count_q    <= '0;
      react_q    <= '0;
      valid_q    <= 1'b0;
      false_q    <= 1'b0;
      tout_q     <= 1'b0;
`ifdef REACTION_BEST_EN
      best_q     <= '1;
`endif
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], i_key_n};
      key_prev_q <= key_s;
      armed_q    <= i_armed;
      count_q    <= count_d;
      react_q    <= react_d;
      valid_q    <= valid_d;
      false_q    <= false_d;
      tout_q     <= tout_d;
`ifdef REACTION_BEST_EN
      best_q     <= best_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    react_d = react_q;
    valid_d = 1'b0;
    false_d = false_q;
    tout_d  = tout_q;
`ifdef REACTION_BEST_EN
    best_d  = best_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (i_armed) state_d = StArmed;
      end
      StArmed: begin
        // A press wins over a coincident lights-out pulse.
        if (press) begin
          state_d = StFalse;
          false_d = 1'b1;
        end else if (i_go) begin
          state_d = StTiming;
          count_d = '0;
        end else if (!i_armed) begin
          state_d = StIdle;
        end
      end
      StTiming: begin
        if (press) begin
          state_d = StDone;
          react_d = count_q;
          valid_d = 1'b1;
`ifdef REACTION_BEST_EN
          if (count_q < best_q) best_d = count_q;
`endif
        end else if (i_tick) begin
          if (count_q == LastVal) begin
            state_d = StTout;
            count_d = TimeoutVal;
            react_d = TimeoutVal;
            tout_d  = 1'b1;
          end else begin
            count_d = count_q + One;
          end
        end
      end
      StDone, StFalse, StTout: begin
        if (arm_rise) begin
          state_d = StArmed;
          false_d = 1'b0;
          tout_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign o_busy       = (state_q == StArmed) || (state_q == StTiming);
  assign o_valid      = valid_q;
  assign o_reactionMs = react_q;
  assign o_falseStart = false_q;
  assign o_timeout    = tout_q;
`ifdef REACTION_BEST_EN
  assign o_best       = best_q;
`endif

endmodule

// File: tb/tb_reaction_timer.sv
// Self-checking bench for reaction_timer: directed scenarios plus randomized runs
// against a transaction-level model (reaction = ticks seen between lights-out and press).
module tb_reaction_timer;

  localparam int unsigned MS_W       = 10;
  localparam int unsigned TIMEOUT_MS = 999;

  logic            i_clk = 1'b0;
  logic            i_srst_n, i_tick, i_armed, i_go, i_key_n;
  logic            o_busy, o_valid, o_falseStart, o_timeout;
  logic [MS_W-1:0] o_reactionMs;
`ifdef REACTION_BEST_EN
  logic [MS_W-1:0] o_best;
`endif

  int n_pass = 0;
  int n_total = 0;
  int vcount = 0;
  int model_last = 0;
  int model_best = (1 << MS_W) - 1;

  always #5 i_clk = ~i_clk;

  reaction_timer #(
    .MS_W       (MS_W),
    .TIMEOUT_MS (TIMEOUT_MS),
    .SYNC_STAGES(2)
  ) dut (
    .i_clk       (i_clk),
    .i_srst_n    (i_srst_n),
    .i_tick      (i_tick),
    .i_armed     (i_armed),
    .i_go        (i_go),
    .i_key_n     (i_key_n),
    .o_busy      (o_busy),
    .o_valid     (o_valid),
    .o_reactionMs(o_reactionMs),
    .o_falseStart(o_falseStart),
    .o_timeout   (o_timeout)
`ifdef REACTION_BEST_EN
    ,
    .o_best      (o_best)
`endif
  );

  // Count valid pulses mid-cycle, away from the active edge.
  always @(negedge i_clk) if (o_valid === 1'b1) vcount++;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  task automatic step(input logic tick);
    i_tick = tick;
    @(posedge i_clk);
    #1;
    i_tick = 1'b0;
  endtask

  task automatic give_go();
    i_go = 1'b1;
    step(1'b0);
    i_go = 1'b0;
  endtask

  task automatic give_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 3) == 0) step(1'b0);
      step(1'b1);
    end
  endtask

  task automatic release_key();
    i_key_n = 1'b1;
    repeat (4) step(1'b0);
  endtask

  task automatic do_reset();
    i_srst_n = 1'b0;
    repeat (3) step(1'b0);
    i_srst_n = 1'b1;
    model_last = 0;
    model_best = (1 << MS_W) - 1;
  endtask

  task automatic rearm(input string name);
    i_armed = 1'b0;
    step(1'b0);
    i_armed = 1'b1;
    step(1'b0);
    n_total++; if (o_busy !== 1'b1) $display("FAIL %s_rearm_busy: got %b want 1", name, o_busy);
    else n_pass++;
    n_total++;
    if (o_falseStart !== 1'b0 || o_timeout !== 1'b0)
      $display("FAIL %s_rearm_flags: got fs=%b to=%b want 0 0", name, o_falseStart, o_timeout);
    else n_pass++;
  endtask

  // Key falls now; tail[i] is the tick driven on the i-th edge after. The press takes
  // effect on the third edge, so only tail[0] and tail[1] count towards the reaction.
  task automatic press_and_check(input string name, input int base, input logic [2:0] tail);
    int v0;
    int exp_r;
    v0 = vcount;
    exp_r = base + int'(tail[0]) + int'(tail[1]);
    if (exp_r > int'(TIMEOUT_MS) - 1) exp_r = int'(TIMEOUT_MS) - 1;
    i_key_n = 1'b0;
    step(tail[0]);
    step(tail[1]);
    n_total++; if (o_valid !== 1'b0) $display("FAIL %s_early_valid: got %b want 0", name, o_valid);
    else n_pass++;
    step(tail[2]);
    n_total++; if (o_valid !== 1'b1) $display("FAIL %s_valid: got %b want 1", name, o_valid);
    else n_pass++;
    n_total++;
    if (o_reactionMs !== MS_W'(exp_r))
      $display("FAIL %s_reaction: got %0d want %0d", name, o_reactionMs, exp_r);
    else n_pass++;
    n_total++;
    if (o_busy !== 1'b0 || o_falseStart !== 1'b0 || o_timeout !== 1'b0)
      $display("FAIL %s_flags: got busy=%b fs=%b to=%b want 0 0 0", name, o_busy, o_falseStart,
               o_timeout);
    else n_pass++;
    model_last = exp_r;
    if (exp_r < model_best) model_best = exp_r;
`ifdef REACTION_BEST_EN
    n_total++;
    if (o_best !== MS_W'(model_best))
      $display("FAIL %s_best: got %0d want %0d", name, o_best, model_best);
    else n_pass++;
`endif
    step(1'b0);
    n_total++;
    if (o_valid !== 1'b0 || vcount - v0 != 1)
      $display("FAIL %s_one_pulse: got valid=%b pulses=%0d want 0 1", name, o_valid, vcount - v0);
    else n_pass++;
  endtask

  task automatic false_start(input string name, input bit coincide_go);
    int v0;
    rearm(name);
    v0 = vcount;
    i_key_n = 1'b0;
    step(1'b0);
    step(1'b0);
    i_go = coincide_go;
    step(1'b0);
    i_go = 1'b0;
    n_total++;
    if (o_falseStart !== 1'b1 || o_busy !== 1'b0)
      $display("FAIL %s_flag: got fs=%b busy=%b want 1 0", name, o_falseStart, o_busy);
    else n_pass++;
    give_go();
    step(1'b1);
    n_total++;
    if (o_busy !== 1'b0 || o_falseStart !== 1'b1 || o_timeout !== 1'b0)
      $display("FAIL %s_go_ignored: got busy=%b fs=%b to=%b want 0 1 0", name, o_busy,
               o_falseStart, o_timeout);
    else n_pass++;
    n_total++;
    if (o_reactionMs !== MS_W'(model_last) || vcount != v0)
      $display("FAIL %s_unchanged: got ms=%0d pulses=%0d want %0d 0", name, o_reactionMs,
               vcount - v0, model_last);
    else n_pass++;
`ifdef REACTION_BEST_EN
    n_total++;
    if (o_best !== MS_W'(model_best))
      $display("FAIL %s_best: got %0d want %0d", name, o_best, model_best);
    else n_pass++;
`endif
  endtask

  task automatic test_reset();
    i_armed = 1'b1;
    i_go = 1'b0;
    i_tick = 1'b0;
    i_key_n = 1'b1;
    do_reset();
    i_armed = 1'b0;
    n_total++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_reactionMs !== '0 || o_falseStart !== 1'b0 ||
        o_timeout !== 1'b0)
      $display("FAIL reset_values: got busy=%b valid=%b ms=%0d fs=%b to=%b want 0 0 0 0 0",
               o_busy, o_valid, o_reactionMs, o_falseStart, o_timeout);
    else n_pass++;
`ifdef REACTION_BEST_EN
    n_total++; if (o_best !== '1) $display("FAIL reset_best: got %0d want all-ones", o_best);
    else n_pass++;
`endif
    step(1'b0);
    give_go();
    n_total++; if (o_busy !== 1'b0) $display("FAIL idle_go_ignored: got %b want 0", o_busy);
    else n_pass++;
    i_armed = 1'b1;
    step(1'b0);
    n_total++; if (o_busy !== 1'b1) $display("FAIL idle_to_armed: got %b want 1", o_busy);
    else n_pass++;
    i_armed = 1'b0;
    step(1'b0);
    n_total++; if (o_busy !== 1'b0) $display("FAIL armed_abort: got %b want 0", o_busy);
    else n_pass++;
  endtask

  task automatic test_normal();
    rearm("normal");
    give_go();
    give_ticks(237);
    press_and_check("normal", 237, 3'b000);
    release_key();
  endtask

  task automatic test_timeout();
    int v0;
    rearm("tout");
    v0 = vcount;
    give_go();
    repeat (TIMEOUT_MS - 1) step(1'b1);
    n_total++;
    if (o_busy !== 1'b1 || o_timeout !== 1'b0)
      $display("FAIL tout_before_last: got busy=%b to=%b want 1 0", o_busy, o_timeout);
    else n_pass++;
    step(1'b1);
    model_last = TIMEOUT_MS;
    n_total++;
    if (o_timeout !== 1'b1 || o_busy !== 1'b0 || o_reactionMs !== MS_W'(TIMEOUT_MS))
      $display("FAIL tout_flag: got to=%b busy=%b ms=%0d want 1 0 %0d", o_timeout, o_busy,
               o_reactionMs, TIMEOUT_MS);
    else n_pass++;
    i_key_n = 1'b0;
    repeat (5) step(1'b1);
    n_total++;
    if (vcount != v0 || o_reactionMs !== MS_W'(TIMEOUT_MS) || o_timeout !== 1'b1)
      $display("FAIL tout_press_ignored: got pulses=%0d ms=%0d to=%b want 0 %0d 1",
               vcount - v0, o_reactionMs, o_timeout, TIMEOUT_MS);
    else n_pass++;
    release_key();
  endtask

  task automatic test_coincidence();
    false_start("go_press", 1'b1);
    release_key();
    rearm("tick500");
    give_go();
    give_ticks(499);
    press_and_check("tick500", 499, 3'b100);
    release_key();
    rearm("last_tick");
    give_go();
    give_ticks(TIMEOUT_MS - 1);
    press_and_check("last_tick", TIMEOUT_MS - 1, 3'b100);
    release_key();
  endtask

  task automatic test_key_held();
    int v0;
    rearm("held_a");
    give_go();
    give_ticks(40);
    press_and_check("held_a", 40, 3'b011);
    rearm("held_b");
    repeat (4) step(1'b0);
    n_total++;
    if (o_falseStart !== 1'b0 || o_busy !== 1'b1)
      $display("FAIL held_no_false: got fs=%b busy=%b want 0 1", o_falseStart, o_busy);
    else n_pass++;
    v0 = vcount;
    give_go();
    give_ticks(20);
    n_total++;
    if (o_busy !== 1'b1 || vcount != v0)
      $display("FAIL held_no_press: got busy=%b pulses=%0d want 1 0", o_busy, vcount - v0);
    else n_pass++;
    i_key_n = 1'b1;
    repeat (4) step(1'b1);
    press_and_check("held_b", 24, 3'b000);
    release_key();
  endtask

  task automatic test_best();
`ifdef REACTION_BEST_EN
    do_reset();
    rearm("best300");
    give_go();
    give_ticks(300);
    press_and_check("best300", 300, 3'b000);
    release_key();
    rearm("best180");
    give_go();
    give_ticks(180);
    press_and_check("best180", 180, 3'b000);
    release_key();
    rearm("best250");
    give_go();
    give_ticks(250);
    press_and_check("best250", 250, 3'b000);
    release_key();
    false_start("best_fs", 1'b0);
    release_key();
`endif
  endtask

  task automatic test_random();
    for (int t = 0; t < 10; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        false_start("rand_fs", 1'($urandom_range(0, 1)));
      end else begin
        int n;
        logic [2:0] tail;
        n = int'($urandom_range(0, 80));
        tail = 3'($urandom_range(0, 7));
        rearm("rand");
        give_go();
        give_ticks(n);
        press_and_check("rand", n, tail);
      end
      release_key();
    end
  endtask

  task automatic test_reset_mid();
    rearm("mid");
    give_go();
    give_ticks(10);
    i_srst_n = 1'b0;
    step(1'b1);
    n_total++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_reactionMs !== '0 || o_falseStart !== 1'b0 ||
        o_timeout !== 1'b0)
      $display("FAIL mid_reset: got busy=%b valid=%b ms=%0d fs=%b to=%b want 0 0 0 0 0",
               o_busy, o_valid, o_reactionMs, o_falseStart, o_timeout);
    else n_pass++;
`ifdef REACTION_BEST_EN
    n_total++; if (o_best !== '1) $display("FAIL mid_reset_best: got %0d want all-ones", o_best);
    else n_pass++;
`endif
    i_armed = 1'b0;
    i_srst_n = 1'b1;
    model_last = 0;
    model_best = (1 << MS_W) - 1;
    step(1'b0);
    n_total++; if (o_busy !== 1'b0) $display("FAIL mid_idle: got %b want 0", o_busy);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_normal();
    false_start("false_start", 1'b0);
    release_key();
    test_timeout();
    test_coincidence();
    test_key_held();
    test_best();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
